// File: rtl/alu_share_scheduler_if.sv
// Handshake bundle between two command requesters, the shared-ALU scheduler
// and the single tagged response consumer.
interface alu_share_scheduler_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_carry;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_y, rsp_carry,
    input  rsp_ready
  );

  // Requester / consumer side.
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_y, rsp_carry,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_scheduler.sv
// Round-robin sharing of one AND/OR/XOR/ADD unit between two requesters,
// one operation in flight, tagged result returned with backpressure.
module alu_share_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_scheduler_if.slave bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  state_t           state, state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             last_grant;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_carry_q;

  logic             grant_id;
  logic             accept;
  logic             rsp_fire;
  logic [WIDTH-1:0] exec_y;
  logic             exec_carry;
  logic [WIDTH:0]   sum;

  // A lone valid wins outright; under contention the requester not served last wins.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant;
    else if (bus.req1_valid)              grant_id = 1'b1;
  end

  assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant_id;
  assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant_id;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign rsp_fire       = (state == RESP) && bus.rsp_ready;

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_y      = rsp_y_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = EXEC;
      EXEC:                  state_nxt = RESP;
      RESP:    if (rsp_fire) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_comb begin
    exec_y     = '0;
    exec_carry = 1'b0;
    unique case (op_q)
      OP_AND: exec_y = a_q & b_q;
      OP_OR:  exec_y = a_q | b_q;
      OP_XOR: exec_y = a_q ^ b_q;
      OP_ADD: {exec_carry, exec_y} = sum;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      last_grant  <= 1'b1;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      done_cnt    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (accept) begin
        op_q       <= op_t'(grant_id ? bus.req1_op : bus.req0_op);
        a_q        <= grant_id ? bus.req1_a : bus.req0_a;
        b_q        <= grant_id ? bus.req1_b : bus.req0_b;
        rsp_id_q   <= grant_id;
        last_grant <= grant_id;
      end
      // Result registers hold their value after the response is consumed.
      if (state == EXEC) begin
        rsp_y_q     <= exec_y;
        rsp_carry_q <= exec_carry;
      end
      if (rsp_fire) done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_share_scheduler.sv
// Scoreboard bench for alu_share_scheduler: a transaction-level model predicts
// grants, latency and results; a separate monitor checks every response.
module tb_alu_share_scheduler;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct {
    logic       id;
    logic [7:0] y;
    logic       c;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  alu_share_scheduler_if #(.WIDTH(WIDTH)) bus ();

  alu_share_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;

  req_t stim0[$];
  req_t stim1[$];
  rsp_t sb[$];

  bit   model_busy = 1'b0;
  int   model_age  = 0;
  bit   model_last = 1'b1;
  int   model_cnt  = 0;
  bit   acc [2];
  int   pops = 0;
  int   pops_id [2];
  bit   rand_gaps = 1'b0;
  bit   rand_ready = 1'b0;
  bit   rsp_ready_hold = 1'b1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result straight from the operation's definition.
  function automatic rsp_t alu_ref(logic id, req_t r);
    rsp_t o;
    int   s;
    o.id = id;
    o.c  = 1'b0;
    case (r.op)
      2'b00:   o.y = r.a & r.b;
      2'b01:   o.y = r.a | r.b;
      2'b10:   o.y = r.a ^ r.b;
      default: begin
        s   = int'(r.a) + int'(r.b);
        o.y = 8'(s % 256);
        o.c = (s > 255);
      end
    endcase
    return o;
  endfunction

  function automatic req_t junk();
    req_t j;
    j.op = 2'($urandom);
    j.a  = 8'($urandom);
    j.b  = 8'($urandom);
    return j;
  endfunction

  function automatic req_t rnd_req();
    return junk();
  endfunction

  task automatic drive(int r, bit v, req_t x);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = x.op; bus.req0_a = x.a; bus.req0_b = x.b;
    end else begin
      bus.req1_valid = v; bus.req1_op = x.op; bus.req1_a = x.a; bus.req1_b = x.b;
    end
  endtask

  // Advance one cycle and drive new stimulus #1 after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      bit   cur_v;
      int   qs;
      req_t head;
      if (acc[r]) begin
        acc[r] = 1'b0;
        if (r == 0) stim0.delete(0);
        else        stim1.delete(0);
        drive(r, 1'b0, junk());
      end
      cur_v = (r == 0) ? bus.req0_valid : bus.req1_valid;
      qs    = (r == 0) ? stim0.size() : stim1.size();
      if (!cur_v) begin
        if (qs > 0 && (!rand_gaps || $urandom_range(3) != 0)) begin
          head = (r == 0) ? stim0[0] : stim1[0];
          drive(r, 1'b1, head);
        end else begin
          drive(r, 1'b0, junk());
        end
      end
    end
    bus.rsp_ready = rand_ready ? ($urandom_range(3) != 0) : rsp_ready_hold;
  endtask

  // Reference model: one operation outstanding, result visible the cycle after
  // execute, round-robin under contention.
  task automatic model_cycle();
    bit v0, v1, g, exp_r0, exp_r1, exp_rv;
    v0     = bus.req0_valid;
    v1     = bus.req1_valid;
    g      = (v0 && v1) ? !model_last : v1;
    exp_r0 = !model_busy && v0 && !g;
    exp_r1 = !model_busy && v1 &&  g;
    exp_rv = model_busy && (model_age >= 1);
    check("req0_ready", bus.req0_ready, exp_r0);
    check("req1_ready", bus.req1_ready, exp_r1);
    check("rsp_valid",  bus.rsp_valid,  exp_rv);
    check("busy",       busy,           model_busy);
    check("done_cnt",   done_cnt,       model_cnt % 256);
    if (model_busy) begin
      if (exp_rv && bus.rsp_ready) begin
        model_busy = 1'b0;
        model_cnt++;
      end else begin
        model_age++;
      end
    end else if (v0 || v1) begin
      sb.push_back(alu_ref(g, g ? stim1[0] : stim0[0]));
      acc[g]     = 1'b1;
      model_last = g;
      model_busy = 1'b1;
      model_age  = 0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) model_cycle();
    end
  end

  // Response monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          check("rsp_id",    bus.rsp_id,    sb[0].id);
          check("rsp_y",     bus.rsp_y,     sb[0].y);
          check("rsp_carry", bus.rsp_carry, sb[0].c);
          if (bus.rsp_ready) begin
            pops_id[sb[0].id]++;
            pops++;
            sb.delete(0);
          end
        end
      end
    end
  end

  task automatic clear_model();
    stim0.delete();
    stim1.delete();
    sb.delete();
    model_busy = 1'b0;
    model_age  = 0;
    model_last = 1'b1;
    model_cnt  = 0;
    acc[0]     = 1'b0;
    acc[1]     = 1'b0;
    drive(0, 1'b0, junk());
    drive(1, 1'b0, junk());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (!(stim0.size() == 0 && stim1.size() == 0 && !bus.req0_valid && !bus.req1_valid
             && !model_busy && sb.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", (n >= budget), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int   p0, p1, base;
    bit   hit;
    req_t r;

    pops_id[0] = 0;
    pops_id[1] = 0;
    rst_n = 1'b0;
    clear_model();
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_id",    bus.rsp_id,    0);
    check("reset_rsp_y",     bus.rsp_y,     0);
    check("reset_rsp_carry", bus.rsp_carry, 0);
    check("reset_busy",      busy,          0);
    check("reset_done_cnt",  done_cnt,      0);
    rst_n = 1'b1;

    // Single OR from requester 0.
    stim0.push_back('{op: 2'b01, a: 8'hF0, b: 8'hAA});
    drain(50);
    check("single_done_cnt", done_cnt, 1);
    check("single_pops", pops, 1);

    // Both requesters held valid: AND on req0, XOR on req1, must alternate.
    do_reset();
    p0 = pops_id[0];
    p1 = pops_id[1];
    for (int i = 0; i < 4; i++) begin
      stim0.push_back('{op: 2'b00, a: 8'h0F, b: 8'hF0});
      stim1.push_back('{op: 2'b10, a: 8'h55, b: 8'hAA});
    end
    drain(100);
    check("contend_req0_served", pops_id[0] - p0, 4);
    check("contend_req1_served", pops_id[1] - p1, 4);

    // ADD carry-out boundary and plain ADD.
    stim1.push_back('{op: 2'b11, a: 8'hFF, b: 8'h01});
    stim1.push_back('{op: 2'b11, a: 8'h12, b: 8'h34});
    drain(50);

    // Backpressure: hold the response for 5 cycles with req0 waiting.
    rsp_ready_hold = 1'b0;
    stim0.push_back('{op: 2'b11, a: 8'h80, b: 8'h81});
    stim0.push_back('{op: 2'b01, a: 8'h01, b: 8'h02});
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = model_busy && model_age >= 1;
    end
    check("bp_reached_resp", hit, 1);
    repeat (5) begin
      step();
      check("bp_req0_waiting", bus.req0_valid, 1);
    end
    rsp_ready_hold = 1'b1;
    drain(50);

    // Reset asserted while executing aborts the operation.
    stim0.push_back('{op: 2'b10, a: 8'h3C, b: 8'hC3});
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = model_busy && model_age == 0;
    end
    check("abort_reached_exec", hit, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_busy",      busy,          0);
    check("abort_rsp_y",     bus.rsp_y,     0);
    check("abort_rsp_carry", bus.rsp_carry, 0);
    check("abort_rsp_id",    bus.rsp_id,    0);
    check("abort_done_cnt",  done_cnt,      0);
    clear_model();
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    stim0.push_back('{op: 2'b00, a: 8'hFF, b: 8'h5A});
    stim1.push_back('{op: 2'b01, a: 8'h00, b: 8'h00});
    step();
    #5;
    check("abort_next_grant0", bus.req0_ready, 1);
    check("abort_next_grant1", bus.req1_ready, 0);
    drain(50);

    // 256 back-to-back responses wrap the counter.
    do_reset();
    base = pops;
    for (int i = 0; i < 256; i++) begin
      r = rnd_req();
      stim0.push_back(r);
    end
    drain(1000);
    check("wrap_responses", pops - base, 256);
    check("wrap_done_cnt",  done_cnt,    0);

    // Randomised traffic with valid gaps and response backpressure.
    rand_gaps  = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      stim0.push_back(rnd_req());
      stim1.push_back(rnd_req());
    end
    drain(5000);
    rand_gaps  = 1'b0;
    rand_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
